// File: rtl/z80_mem_mapper.sv
// Z80 paged memory mapper: I/O-programmed page registers, boot ROM overlay with shadow writes,
// and a WAIT-stretching handshake to an external RAM with an access timeout.
module z80_mem_mapper #(
  parameter int unsigned PAGE_BITS = 2,
  parameter int unsigned PHYS_BITS = 8,
  parameter logic [7:0]  IO_BASE   = 8'h78,
  parameter logic [7:0]  ROM_PORT  = 8'h38,
  parameter int unsigned ROM_BITS  = 13,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                            clk,
  input  logic                            n_reset,
  input  logic [15:0]                     cpu_addr,
  input  logic                            n_mreq,
  input  logic                            n_iorq,
  input  logic                            n_rd,
  input  logic                            n_wr,
  input  logic [7:0]                      cpu_dout,
  output logic [7:0]                      map_dout,
  output logic                            map_rd_sel,
  output logic [PHYS_BITS+15-PAGE_BITS:0] phys_addr,
  output logic                            rom_cs,
  output logic                            ram_req,
  output logic                            ram_we,
  input  logic                            ram_ack,
  output logic                            n_wait
);

  localparam int unsigned NumPages = 1 << PAGE_BITS;
  localparam int unsigned OffBits  = 16 - PAGE_BITS;
  localparam int unsigned PhysW    = PHYS_BITS + OffBits;
  localparam int unsigned CntW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWack, StHold} state_e;

  state_e               state_q, state_d;
  logic [PHYS_BITS-1:0] page_q [NumPages];
  logic                 map_en_q, err_q, rom_active_q, io_wr_q, ram_we_q;
  logic [PhysW-1:0]     phys_q, phys_xlat;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 io_wr, io_rd, io_wr_edge, page_hit, ctrl_hit, rom_region;
  logic                 mem_req, start, err_set, n_wait_c;
  logic [7:0]           port_off;
  logic [PAGE_BITS-1:0] page_idx, win;

  assign io_wr      = !n_iorq && !n_wr;
  assign io_rd      = !n_iorq && !n_rd;
  assign io_wr_edge = io_wr && !io_wr_q;
  assign port_off   = cpu_addr[7:0] - IO_BASE;
  assign page_idx   = port_off[PAGE_BITS-1:0];
  assign page_hit   = {1'b0, port_off} < 9'(NumPages);
  assign ctrl_hit   = {1'b0, port_off} == 9'(NumPages);
  assign win        = cpu_addr[15:OffBits];
  assign rom_region = (32'(cpu_addr) >> ROM_BITS) == 32'd0;

  assign phys_xlat = map_en_q ? {page_q[win], cpu_addr[OffBits-1:0]} : PhysW'(cpu_addr);
  // Hold the translation captured at request time for the rest of the access.
  assign phys_addr = (state_q == StIdle) ? phys_xlat : phys_q;

  assign rom_cs  = rom_active_q && !n_mreq && !n_rd && rom_region;
  assign mem_req = !n_mreq && (!n_rd || !n_wr) && !rom_cs;
  assign ram_we  = ram_we_q;
  assign n_wait  = n_wait_c || !n_reset;

  always_comb begin
    map_dout   = '0;
    map_rd_sel = 1'b0;
    if (io_rd && n_reset) begin
      if (page_hit) begin
        map_rd_sel = 1'b1;
        map_dout   = 8'(page_q[page_idx]);
      end else if (ctrl_hit) begin
        map_rd_sel = 1'b1;
        map_dout   = {err_q, 6'b0, map_en_q};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_wait_c = 1'b1;
    ram_req  = 1'b0;
    start    = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          state_d  = StReq;
          n_wait_c = 1'b0;
          start    = 1'b1;
        end
      end
      StReq: begin
        ram_req  = 1'b1;
        n_wait_c = 1'b0;
        cnt_d    = '0;
        state_d  = StWack;
      end
      StWack: begin
        n_wait_c = 1'b0;
        if (ram_ack) begin
          state_d = StHold;
        end else if (cnt_q >= CntW'(TIMEOUT - 1)) begin
          state_d = StHold;
          err_set = 1'b1;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (n_mreq) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NumPages; i++) page_q[i] <= PHYS_BITS'(i);
      map_en_q     <= 1'b0;
      err_q        <= 1'b0;
      rom_active_q <= 1'b1;
      io_wr_q      <= 1'b0;
      ram_we_q     <= 1'b0;
      phys_q       <= '0;
      cnt_q        <= '0;
      state_q      <= StIdle;
    end else begin
      io_wr_q <= io_wr;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (io_wr_edge && page_hit) page_q[page_idx] <= cpu_dout[PHYS_BITS-1:0];
      if (io_wr_edge && ctrl_hit) begin
        map_en_q <= cpu_dout[0];
        if (cpu_dout[7]) err_q <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
      if (io_wr_edge && cpu_addr[7:0] == ROM_PORT) rom_active_q <= 1'b0;
      if (start) begin
        ram_we_q <= !n_wr;
        phys_q   <= phys_xlat;
      end
    end
  end

endmodule

// File: doc/z80_mem_mapper.md
Z80_MEM_MAPPER -- requirements
Module: z80_mem_mapper

Interface
REQ-001 SHALL take parameter PAGE_BITS, default 2; logical window-select bits, giving 2^PAGE_BITS windows of 2^(16-PAGE_BITS) bytes.
REQ-002 SHALL take parameter PHYS_BITS, default 8, range 1..8; physical page-number width.
REQ-003 SHALL take parameter IO_BASE, default 8'h78; first page-register I/O port.
REQ-004 SHALL take parameter ROM_PORT, default 8'h38; ROM-disable I/O port.
REQ-005 SHALL take parameter ROM_BITS, default 13; ROM overlay covers 0000..2^ROM_BITS-1.
REQ-006 SHALL take parameter TIMEOUT, default 255; maximum wait cycles per RAM access.
REQ-007 SHALL have port clk, in, 1: sole clock; all state on its rising edge.
REQ-008 SHALL have port n_reset, in, 1: reset, asynchronous, active-low.
REQ-009 SHALL have ports cpu_addr, in, 16; n_mreq, n_iorq, n_rd, n_wr, in, 1 each; cpu_dout, in, 8: Z80 bus.
REQ-010 SHALL have port map_dout, out, 8: register readback; map_rd_sel, out, 1: high while map_dout is to be muxed onto the CPU data bus.
REQ-011 SHALL have port phys_addr, out, PHYS_BITS+16-PAGE_BITS: translated address.
REQ-012 SHALL have ports rom_cs, out, 1; ram_req, out, 1; ram_we, out, 1; ram_ack, in, 1; n_wait, out, 1: Z80 WAIT.

Function
REQ-013 SHALL drive phys_addr = {page[w], cpu_addr[15-PAGE_BITS:0]}, w = cpu_addr[15:16-PAGE_BITS], when map_en = 1; otherwise phys_addr = cpu_addr, zero-extended; combinational.
REQ-014 SHALL define io_wr = !n_iorq & !n_wr and io_rd = !n_iorq & !n_rd, and SHALL act on a register write once per I/O cycle, in the first clk on which io_wr is sampled high after being sampled low.
REQ-015 SHALL write page[i] <= cpu_dout[PHYS_BITS-1:0] on an io_wr edge to port IO_BASE+i, for 0 <= i < 2^PAGE_BITS.
REQ-016 SHALL treat port IO_BASE+2^PAGE_BITS as CTRL: on write, bit0 -> map_en; bit7 written 1 clears err; other bits ignored.
REQ-017 SHALL assert map_rd_sel combinationally during io_rd to any page or CTRL port and drive map_dout as follows: page ports return page[i], zero-extended; CTRL returns {err, 6'b0, map_en}.
REQ-018 SHALL clear rom_active on an io_wr edge to ROM_PORT, regardless of data; only reset sets it again.
REQ-019 SHALL drive rom_cs = rom_active & !n_mreq & !n_rd & cpu_addr < 2^ROM_BITS.
REQ-020 SHALL route memory writes within the ROM region to RAM (shadow write) while rom_active = 1.
REQ-021 SHALL implement wait FSM states IDLE, REQ, WACK, HOLD.
REQ-022 IDLE -> REQ when !n_mreq & (!n_rd | !n_wr) & !rom_cs; n_wait SHALL go low combinationally in that same cycle.
REQ-023 REQ: ram_req = 1 for exactly one clk; ram_we latched = !n_wr; -> WACK.
REQ-024 WACK: n_wait = 0; a ram_ack sampled high -> HOLD, n_wait = 1 next cycle; ram_ack in the REQ cycle SHALL be ignored.
REQ-025 WACK timeout: after TIMEOUT clks without ram_ack -> HOLD and set err (sticky).
REQ-026 HOLD: n_wait = 1; -> IDLE when n_mreq is sampled high; no new request until then.
REQ-027 SHALL ignore ram_ack in IDLE, REQ and HOLD.
REQ-028 SHALL keep phys_addr and ram_we stable from REQ through HOLD.
REQ-029 SHALL keep the timeout counter width ceil(log2(TIMEOUT+1)) and saturate it, never wrapping.

Reset
REQ-030 SHALL on n_reset low immediately set page[i] = i (truncated to PHYS_BITS), map_en = 0, err = 0, rom_active = 1, FSM = IDLE, ram_req = 0, ram_we = 0, n_wait = 1, map_rd_sel = 0.
REQ-031 SHALL, on reset asserted mid-access, abandon the access with no further ram_req and no completion.

Verification
REQ-032 Reset, then memory read at 0x0100 -> rom_cs = 1, ram_req never pulses, n_wait stays 1.
REQ-033 OUT (0x38), then read at 0x0100 -> rom_cs = 0, ram_req pulses once, n_wait low until ram_ack, phys_addr = 0x00100.
REQ-034 OUT 0x78+2 <- 0x35, OUT 0x7C <- 0x01, then write at 0x8123 -> phys_addr = 0xD4123, ram_we = 1; IN 0x7A returns 0x35.
REQ-035 Request with ram_ack held 0 -> n_wait releases after 255 clks; IN 0x7C returns 0x81; OUT 0x7C <- 0x81 clears err.
REQ-036 n_reset pulsed during WACK -> n_wait = 1 and FSM = IDLE immediately; page registers back to identity; no ram_req.
REQ-037 Single io_wr held low for 10 clks to 0x78 -> exactly one register update.
